// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer on FPGA_CLK.
// Start-bit detection, mid-bit sampling and deframing, with a one-entry
// valid/ready holding register and framing/overrun error pulses.
// Optional feature: define UART_RX_PARITY_EN for 8E1 framing with PARITY_ERR;
// when it is undefined the block deframes 8N1 and PARITY_ERR is tied low.
module uart_rx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       FPGA_CLK,
  input  logic       RST_N,
  input  logic       UART_RXD,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  input  logic       RX_READY,
  output logic       BUSY,
  output logic       FRAME_ERR,
  output logic       OVERRUN,
  output logic       PARITY_ERR
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             sync_meta, sync_cur, sync_prev;
  logic             cnt_clr;
  logic             shift_en;
  logic             stop_sample;
  logic             par_ok;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge FPGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_meta <= 1'b1;
      sync_cur  <= 1'b1;
      sync_prev <= 1'b1;
    end else begin
      sync_meta <= UART_RXD;
      sync_cur  <= sync_meta;
      sync_prev <= sync_cur;
    end
  end

  // FSM state register
  always_ff @(posedge FPGA_CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_next;
  end

`ifdef UART_RX_PARITY_EN
  logic par_en;
`endif

  // Next-state decode and per-cycle datapath strobes
  always_comb begin
    state_next  = state;
    shift_en    = 1'b0;
    stop_sample = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en      = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
        if (sync_prev && !sync_cur) state_next = S_START;
      end
      S_START: begin
        if (cnt == HALF_CNT) state_next = sync_cur ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (cnt == LAST_CNT) begin
          shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx == 3'd7) state_next = S_PARITY;
`else
          if (bit_idx == 3'd7) state_next = S_STOP;
`endif
        end
      end
      S_PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (cnt == LAST_CNT) begin
          par_en     = 1'b1;
          state_next = S_STOP;
        end
`else
        state_next = S_IDLE;
`endif
      end
      S_STOP: begin
        if (cnt == LAST_CNT) begin
          stop_sample = 1'b1;
          state_next  = sync_cur ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        if (sync_cur) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    // Counter restarts on every state entry and at each data-bit boundary,
    // so non-power-of-two bit periods wrap correctly within DATA.
    cnt_clr = (state_next != state) || shift_en;
  end

  assign BUSY = (state != S_IDLE);

  // Bit counter, bit index and LSB-first shift register
  always_ff @(posedge FPGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + CNT_W'(1);
      if (shift_en) begin
        shift_reg <= {sync_cur, shift_reg[7:1]};
        bit_idx   <= bit_idx + 3'd1;
      end else if (state != S_DATA) begin
        bit_idx <= '0;
      end
    end
  end

  // Holding register handshake, commit and framing/overrun pulses
  always_ff @(posedge FPGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      RX_DATA   <= '0;
      RX_VALID  <= 1'b0;
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
      if (RX_VALID && RX_READY) RX_VALID <= 1'b0;
      if (stop_sample && par_ok) begin
        if (!sync_cur) begin
          FRAME_ERR <= 1'b1;
        end else if (RX_VALID && !RX_READY) begin
          OVERRUN <= 1'b1;
        end else begin
          RX_VALID <= 1'b1;
          RX_DATA  <= shift_reg;
        end
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;

  assign par_ok = ~^{shift_reg, par_bit};

  // Captured parity bit and parity-mismatch pulse at the stop-bit sample
  always_ff @(posedge FPGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      par_bit    <= 1'b0;
      PARITY_ERR <= 1'b0;
    end else begin
      if (par_en) par_bit <= sync_cur;
      PARITY_ERR <= stop_sample && !par_ok;
    end
  end
`else
  assign par_ok     = 1'b1;
  assign PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench for uart_rx_ctrl with CLKS_PER_BIT=8.
// Frames are built bit by bit; expected bytes are queued when sent and popped
// when the holding register hands a byte over.
module tb_uart_rx_ctrl;

  localparam int unsigned CPB = 8;
`ifdef UART_RX_PARITY_EN
  localparam bit USE_PAR = 1'b1;
`else
  localparam bit USE_PAR = 1'b0;
`endif

  logic       FPGA_CLK = 1'b0;
  logic       RST_N;
  logic       UART_RXD;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       RX_READY;
  logic       BUSY;
  logic       FRAME_ERR;
  logic       OVERRUN;
  logic       PARITY_ERR;

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .FPGA_CLK  (FPGA_CLK),
    .RST_N     (RST_N),
    .UART_RXD  (UART_RXD),
    .RX_DATA   (RX_DATA),
    .RX_VALID  (RX_VALID),
    .RX_READY  (RX_READY),
    .BUSY      (BUSY),
    .FRAME_ERR (FRAME_ERR),
    .OVERRUN   (OVERRUN),
    .PARITY_ERR(PARITY_ERR)
  );

  always #5 FPGA_CLK = ~FPGA_CLK;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [7:0]  exp_q[$];
  int unsigned valid_cycles, frame_cnt, overrun_cnt, parity_cnt;
  bit          lat_en   = 1'b0;
  bit          lat_done = 1'b0;
  time         start_t  = 0;
  logic        valid_d  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Monitor: count output activity and pop the scoreboard on each handshake
  always @(negedge FPGA_CLK) begin
    if (RST_N) begin
      if (RX_VALID)   valid_cycles++;
      if (FRAME_ERR)  frame_cnt++;
      if (OVERRUN)    overrun_cnt++;
      if (PARITY_ERR) parity_cnt++;
      if (lat_en && RX_VALID && !valid_d) begin
        check("latency_window", 32'(int'(($time - start_t) / 10) inside {[77:80]}), 32'd1);
        lat_en   = 1'b0;
        lat_done = 1'b1;
      end
      if (RX_VALID && RX_READY) begin
        if (exp_q.size() == 0) check("sb_depth", 32'(exp_q.size()), 32'd1);
        else check("rx_data", {24'b0, RX_DATA}, {24'b0, exp_q.pop_front()});
      end
    end
    valid_d = RX_VALID;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge FPGA_CLK);
    #2;
  endtask

  task automatic clear_counts();
    valid_cycles = 0;
    frame_cnt    = 0;
    overrun_cnt  = 0;
    parity_cnt   = 0;
  endtask

  task automatic drive_bit(input logic b);
    UART_RXD = b;
    repeat (CPB) tick();
  endtask

  // Line is left at the stop-bit value so a low stop bit continues as a break
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    start_t = $time;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (USE_PAR) drive_bit(par_b);
    drive_bit(stop_b);
  endtask

  initial begin
    RST_N    = 1'b0;
    UART_RXD = 1'b1;
    RX_READY = 1'b0;
    repeat (3) tick();
    check("rst_data",   {24'b0, RX_DATA}, 32'h0);
    check("rst_valid",  RX_VALID,   32'd0);
    check("rst_busy",   BUSY,       32'd0);
    check("rst_ferr",   FRAME_ERR,  32'd0);
    check("rst_ovr",    OVERRUN,    32'd0);
    check("rst_perr",   PARITY_ERR, 32'd0);
    RST_N = 1'b1;
    repeat (3) tick();

    // Single byte, consumer always ready
    RX_READY = 1'b1;
    clear_counts();
    exp_q.push_back(8'hA5);
    lat_en = 1'b1;
    send_frame(8'hA5, 1'b1, ^8'hA5);
    repeat (10) tick();
    check("t1_valid_cycles", valid_cycles, 32'd1);
    check("t1_latency_seen", lat_done,     32'd1);
    check("t1_ferr",         frame_cnt,    32'd0);
    check("t1_ovr",          overrun_cnt,  32'd0);
    check("t1_perr",         parity_cnt,   32'd0);
    check("t1_sb_empty",     32'(exp_q.size()), 32'd0);
    check("t1_busy",         BUSY,         32'd0);

    // Overrun: second byte arrives while the first is still held
    RX_READY = 1'b0;
    clear_counts();
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, ^8'h3C);
    send_frame(8'h81, 1'b1, ^8'h81);
    repeat (10) tick();
    check("t2_data_held", {24'b0, RX_DATA}, 32'h3C);
    check("t2_valid",     RX_VALID,    32'd1);
    check("t2_ovr",       overrun_cnt, 32'd1);
    check("t2_ferr",      frame_cnt,   32'd0);
    RX_READY = 1'b1;
    repeat (3) tick();
    check("t2_valid_drop", RX_VALID, 32'd0);
    check("t2_sb_empty",   32'(exp_q.size()), 32'd0);

    // Short low glitch is rejected in START
    clear_counts();
    UART_RXD = 1'b0;
    repeat (3) tick();
    UART_RXD = 1'b1;
    repeat (2) tick();
    check("t3_busy_start", BUSY, 32'd1);
    repeat (20) tick();
    check("t3_busy_idle", BUSY,         32'd0);
    check("t3_valid",     valid_cycles, 32'd0);
    check("t3_ferr",      frame_cnt,    32'd0);

    // Stop bit low, line held low 20 cycles from the stop bit
    clear_counts();
    send_frame(8'h55, 1'b0, ^8'h55);
    repeat (12) tick();
    check("t4_ferr",       frame_cnt, 32'd1);
    check("t4_busy_break", BUSY,      32'd1);
    UART_RXD = 1'b1;
    repeat (30) tick();
    check("t4_busy_idle", BUSY,         32'd0);
    check("t4_valid",     valid_cycles, 32'd0);
    check("t4_ovr",       overrun_cnt,  32'd0);
    check("t4_perr",      parity_cnt,   32'd0);

    // Reset during bit 4 of 0xFF, then a clean frame
    clear_counts();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    UART_RXD = 1'b1;
    repeat (3) tick();
    RST_N = 1'b0;
    #1;
    check("t5_rst_data",  {24'b0, RX_DATA}, 32'h0);
    check("t5_rst_valid", RX_VALID,  32'd0);
    check("t5_rst_busy",  BUSY,      32'd0);
    check("t5_rst_ferr",  FRAME_ERR, 32'd0);
    check("t5_rst_ovr",   OVERRUN,   32'd0);
    repeat (2) tick();
    RST_N = 1'b1;
    repeat (3) tick();
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, ^8'h12);
    repeat (10) tick();
    check("t5_valid_cycles", valid_cycles, 32'd1);
    check("t5_ferr",         frame_cnt,    32'd0);
    check("t5_sb_empty",     32'(exp_q.size()), 32'd0);

`ifdef UART_RX_PARITY_EN
    // Wrong parity bit, then correct parity bit
    clear_counts();
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (10) tick();
    check("t6_perr",  parity_cnt,   32'd1);
    check("t6_ferr",  frame_cnt,    32'd0);
    check("t6_valid", valid_cycles, 32'd0);
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (10) tick();
    check("t6_perr_once",   parity_cnt,   32'd1);
    check("t6_valid_cycle", valid_cycles, 32'd1);
    check("t6_sb_empty",    32'(exp_q.size()), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
